// File: rtl/fetch_buffer_pkg.sv
// Shared types and defaults for the fetch buffer: data widths, buffer depth
// and the (pc, instr) entry handed to decode.
package fetch_buffer_pkg;

  localparam int FB_XLEN  = 32;
  localparam int FB_DEPTH = 4;

  typedef struct packed {
    logic [FB_XLEN-1:0] pc;
    logic [FB_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers and a synchronous clear.
// The head word is read straight from the storage array at the read pointer.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which words are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer between PC generator and decode: issues in-order instruction
// memory requests on credit, tags responses with their PC, and drops stale work on flush.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int XLEN  = FB_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_stall,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr,
  input  logic            dec_ready
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] tag_count;
  logic [CW:0]   in_use;
  logic          accept;
  logic          resp_keep;
  logic          dec_pop;
  logic          tag_full, tag_empty;
  logic          instr_full, instr_empty;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // Outstanding requests still count against credit while their responses are being discarded.
  assign in_use         = (CW+1)'(occupancy) + (CW+1)'(outstanding);
  assign imem_req_valid = !reset && !flush && (in_use < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign fetch_stall    = !accept;

  assign resp_keep = imem_resp_valid && (discard == '0) && !flush;
  assign wr_entry  = '{pc: tag_pc, instr: imem_resp_data};

  assign dec_valid = !reset && !instr_empty;
  assign dec_pop   = dec_valid && dec_ready;
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (resp_keep),
    .pop_data  (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (resp_keep),
    .push_data (wr_entry),
    .pop       (dec_pop),
    .pop_data  (head),
    .full      (instr_full),
    .empty     (instr_empty),
    .count     (occupancy)
  );

  // On flush every request still in flight after this cycle's response becomes stale.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
      if (flush)
        discard <= outstanding - CW'(imem_resp_valid);
      else if (imem_resp_valid && (discard != '0))
        discard <= discard - 1'b1;
    end
  end

  a_resp_without_request: assert property (@(posedge clock) disable iff (reset)
    imem_resp_valid |-> (outstanding != '0));
  a_credit_bound: assert property (@(posedge clock) disable iff (reset)
    in_use <= DEPTH_W);
  a_tag_accounting: assert property (@(posedge clock) disable iff (reset)
    ({1'b0, tag_count} + {1'b0, discard}) == {1'b0, outstanding});
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(accept && tag_full) && !(resp_keep && instr_full));
  a_tag_present: assert property (@(posedge clock) disable iff (reset)
    resp_keep |-> !tag_empty);

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: a queue-level reference model predicts the
// request channel and the decode stream; a negedge monitor compares the DUT against it.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clock;
  logic            reset;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_stall;
  logic            flush;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            dec_valid;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_instr;
  logic            dec_ready;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_pc        (fetch_pc),
    .fetch_stall     (fetch_stall),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_pc          (dec_pc),
    .dec_instr       (dec_instr),
    .dec_ready       (dec_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: requests in flight (marked stale by a flush) and the decode queue.
  typedef struct {
    logic [XLEN-1:0] pc;
    bit              stale;
  } flight_t;

  flight_t      inflight[$];
  fetch_entry_t expq[$];

  initial begin : monitor
    bit      exp_rv;
    flight_t f;
    forever begin
      @(negedge clock);
      if (reset) begin
        check("reset_req_valid", imem_req_valid, 1'b0);
        check("reset_dec_valid", dec_valid, 1'b0);
        check("reset_fetch_stall", fetch_stall, 1'b1);
        inflight.delete();
        expq.delete();
      end else begin
        exp_rv = !flush && ((expq.size() + inflight.size()) < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        check("fetch_stall", fetch_stall, !(exp_rv && imem_req_ready));
        if (exp_rv) check("req_addr", imem_req_addr, fetch_pc);
        check("dec_valid", dec_valid, expq.size() > 0);
        if (expq.size() > 0) begin
          check("dec_pc", dec_pc, expq[0].pc);
          check("dec_instr", dec_instr, expq[0].instr);
          if (dec_ready) void'(expq.pop_front());
        end
        if (imem_resp_valid) begin
          check("resp_has_request", inflight.size() != 0, 1'b1);
          if (inflight.size() != 0) begin
            f = inflight.pop_front();
            if (!flush && !f.stale) expq.push_back('{pc: f.pc, instr: imem_resp_data});
          end
        end
        if (exp_rv && imem_req_ready) inflight.push_back('{pc: fetch_pc, stale: 1'b0});
        if (flush) begin
          expq.delete();
          foreach (inflight[i]) inflight[i].stale = 1'b1;
        end
      end
    end
  end

  // Instruction memory: in-order responses, random latency >= 1, no backpressure.
  typedef struct {
    logic [XLEN-1:0] data;
    int              due;
  } mresp_t;

  mresp_t          memq[$];
  int              cyc;
  logic [XLEN-1:0] pc_gen;

  task automatic step(input int p_rr, input int p_dr, input int p_fl, input int lat_max);
    imem_req_ready = ($urandom_range(99) < p_rr);
    dec_ready      = ($urandom_range(99) < p_dr);
    flush          = ($urandom_range(99) < p_fl);
    if (flush) pc_gen = 32'h100 + (32'($urandom_range(63)) << 2);
    fetch_pc = pc_gen;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memq[0].data;
      void'(memq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #7;
    if (!fetch_stall) begin
      pc_gen = pc_gen + 32'd4;
      memq.push_back('{data: $urandom, due: cyc + int'($urandom_range(lat_max, 1))});
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic run_phase(input int n, input int p_rr, input int p_dr, input int p_fl, input int lat_max);
    repeat (n) step(p_rr, p_dr, p_fl, lat_max);
  endtask

  task automatic apply_reset(input int n);
    reset           = 1'b1;
    flush           = 1'b0;
    imem_resp_valid = 1'b0;
    memq.delete();
    repeat (n) begin
      @(posedge clock);
      cyc++;
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    flush           = 1'b0;
    fetch_pc        = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    dec_ready       = 1'b0;
    pc_gen          = '0;
    cyc             = 0;
    apply_reset(3);

    //        cycles  req_ready%  dec_ready%  flush%  max_latency
    run_phase(40,     100,        100,        0,      1);  // steady stream from pc 0
    run_phase(20,     100,        0,          0,      1);  // decode backpressure fills credit
    run_phase(20,     100,        100,        0,      1);  // release and resume
    run_phase(3,      0,          100,        0,      1);  // memory backpressure holds pc
    run_phase(20,     100,        100,        0,      1);
    run_phase(300,    80,         80,         10,     3);  // flushes with requests in flight
    run_phase(200,    70,         60,         20,     1);  // flushes coincident with responses
    run_phase(8,      100,        0,          0,      2);  // build up work, then reset
    apply_reset(2);
    run_phase(300,    80,         50,         5,      4);
    run_phase(30,     100,        100,        0,      1);  // drain

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Sits between the fetch PC generator and decode.
- Sends the current fetch PC to instruction memory over a valid/ready request channel and pairs each in-order response with its PC.
- Buffers (pc, instr) pairs in a small FIFO for decode.
- Drives the stall input of the PC generator so the PC advances only when a request is accepted; flushes in-flight and buffered work on a control-flow redirect.

Parameters:
- DEPTH, 4, max entries of buffered plus outstanding instructions (power of two, >=2)
- XLEN, 32, PC and instruction width

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- fetch_pc  input  XLEN  current PC from PC generator
- fetch_stall  output  1  hold PC this cycle (to PC generator stall_en)
- flush  input  1  redirect taken (jal/jalr); discard all younger work
- imem_req_valid  output  1  request valid
- imem_req_addr  output  XLEN  request address (= fetch_pc)
- imem_req_ready  input  1  memory accepts request
- imem_resp_valid  input  1  response valid; in order, latency >=1, no backpressure
- imem_resp_data  input  XLEN  instruction word
- dec_valid  output  1  head entry valid
- dec_pc  output  XLEN  head entry PC
- dec_instr  output  XLEN  head entry instruction
- dec_ready  input  1  decode consumes head

Behaviour:
- Clock and reset: clock is clock; reset is reset, synchronous, active-high. While reset is high, imem_req_valid=0, dec_valid=0, fetch_stall=1.
- Reset state: FIFO empty, outstanding=0, discard=0.
- State: the PC tag queue (DEPTH) holds PCs of outstanding requests. The instruction FIFO (DEPTH) holds (pc, instr). Counter outstanding (0..DEPTH). Counter discard (0..DEPTH).
- Credit rule: imem_req_valid = !reset & !flush & (occupancy + outstanding < DEPTH).
- Request accept: imem_req_valid & imem_req_ready. On accept, push fetch_pc to the tag queue and increment outstanding.
- Stall: fetch_stall = !(imem_req_valid & imem_req_ready). Combinational, same cycle.
- Response with discard>0: decrement discard and outstanding; the data is dropped and the tag queue is untouched.
- Response with discard=0: pop the tag queue, push (tag, imem_resp_data) into the FIFO, decrement outstanding.
- Response latency: a response is visible on dec_* the next cycle (1-cycle latency).
- Decode side: dec_valid = FIFO non-empty. dec_pc/dec_instr are registered head data. Pop on dec_valid & dec_ready.
- Simultaneous events: push and pop in the same cycle keep occupancy unchanged; push into a full FIFO cannot happen because of credits. Accept plus response in the same cycle updates outstanding net +0.
- Flush: in the flush cycle no request is issued and no response is written into the FIFO. Next state:
  - FIFO empty, tag queue empty.
  - discard = outstanding after counting this cycle's response (i.e. outstanding - resp_valid) + existing discard handling.
  - dec_valid=0 from the next cycle.
- Flush with discard already nonzero: discard is reloaded as the total outstanding, never double-counted.
- Wrap-around: pointers are log2(DEPTH)+1 bits; full/empty are computed from the MSB compare.
- Assertions:
  - A response when outstanding=0 is an error.
  - outstanding + occupancy <= DEPTH at all times.

Decomposition:
- Shared package: XLEN, a fetch_entry struct {pc, instr}, and a DEPTH default constant.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count, synchronous clear). It is instantiated twice: the tag queue (XLEN) and the instruction FIFO (2*XLEN).

Test Plan:
- Steady stream: reset, then ready=1, response latency 1, dec_ready=1, fetch_pc 0,4,8,... -> dec_pc 0x0,0x4,0x8 on consecutive cycles; fetch_stall=0 after the first accept; dec_instr matches memory.
- Decode backpressure: dec_ready=0, latency 1 -> exactly DEPTH=4 requests issued (pc 0..0xC), then imem_req_valid=0 and fetch_stall=1. Releasing dec_ready resumes issue within 1 cycle and preserves order.
- Memory backpressure: imem_req_ready=0 for 3 cycles -> fetch_stall=1 for those 3 cycles and fetch_pc is held. The next accepted address equals the held pc.
- Flush mid-flight: latency 3, two requests outstanding (0x10, 0x14) and FIFO holding 0xC; assert flush with fetch_pc redirected to 0x100 -> discard=2. Both stale responses are dropped and 0xC disappears. The first dec_pc after the flush is 0x100.
- Flush coincident with response: a response arrives in the flush cycle with outstanding=1 -> discard=0 afterwards and nothing is enqueued. The next request issues in the cycle after the flush.
- Reset mid-operation: reset asserted with FIFO holding 3 entries and 1 outstanding -> dec_valid=0 and imem_req_valid=0 during reset. After release, counters are zero and the first request carries the current fetch_pc.
